// File: rtl/seq_detect_ctrl.sv
// Accepts a DATA_W word, shifts it MSB-first through a programmable PAT_W-bit Moore matcher and returns the overlap match count.
// Latency: accept edge to out_valid is DATA_W edges; result and in_ready=0 are held in DONE until out_ready.
module seq_detect_ctrl #(
    parameter int PAT_W                       = 4,
    parameter int DATA_W                      = 8,
    parameter logic [PAT_W-1:0] RESET_PATTERN = PAT_W'(4'b1101),
    localparam int CNT_W                      = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              seq_detected,
    output logic [PAT_W-1:0]  current_seq,
    output logic              busy
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   word;
    logic [IDX_W-1:0]    idx;
    logic [PAT_W-1:0]    hist;
    logic [FILL_W-1:0]   fill;
    logic [CNT_W-1:0]    count;
    logic [PAT_W-1:0]    pattern;

    logic [PAT_W-1:0]    next_hist;
    logic [FILL_W-1:0]   next_fill;
    logic                hit;

    // Match is judged on the post-shift history so a pattern completing on this edge pulses next cycle.
    always_comb begin
        next_hist = {hist[PAT_W-2:0], word[idx]};
        next_fill = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit       = (next_fill == FILL_FULL) && (next_hist == pattern);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            word         <= '0;
            idx          <= '0;
            hist         <= '0;
            fill         <= '0;
            count        <= '0;
            pattern      <= RESET_PATTERN;
            seq_detected <= 1'b0;
        end else begin
            seq_detected <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Config lands on the same edge as an accept, so the new word sees clean history.
                    if (cfg_wr) begin
                        pattern <= cfg_pattern;
                        hist    <= '0;
                        fill    <= '0;
                    end
                    if (in_valid) begin
                        word  <= in_data;
                        count <= '0;
                        idx   <= IDX_TOP;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    hist <= next_hist;
                    fill <= next_fill;
                    idx  <= idx - IDX_W'(1);
                    if (hit) begin
                        seq_detected <= 1'b1;
                        count        <= count + CNT_W'(1);
                    end
                    if (idx == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign out_count   = count;
    assign current_seq = hist;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with PAT_W=4, DATA_W=8 and hand-computed expectations.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_wr;
    logic [3:0] cfg_pattern;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;
    logic       seq_detected;
    logic [3:0] current_seq;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .PAT_W(4),
        .DATA_W(8),
        .RESET_PATTERN(4'b1101)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cfg_wr(cfg_wr),
        .cfg_pattern(cfg_pattern),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .seq_detected(seq_detected),
        .current_seq(current_seq),
        .busy(busy)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        cfg_wr    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic accept_word(input logic [7:0] d, input logic cfg, input logic [3:0] pat);
        int t;
        @(negedge clk);
        in_data     = d;
        in_valid    = 1'b1;
        cfg_wr      = cfg;
        cfg_pattern = pat;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_wr   = 1'b0;
    endtask

    // Runs the eight shift edges; pulses[k] records seq_detected after shift edge k.
    task automatic shift_word(input string tag, output logic [8:0] pulses);
        pulses = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            pulses[k] = seq_detected;
            if (k == 7) check({tag, "_valid_e7"}, out_valid, 0);
            if (k == 8) check({tag, "_valid_e8"}, out_valid, 1);
        end
    endtask

    task automatic read_result(output int cnt);
        cnt = out_count;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [8:0] pulses;
        int         cnt;
        logic       saw_valid;

        reset_n     = 1'b1;
        cfg_wr      = 1'b0;
        cfg_pattern = 4'b0000;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_det", seq_detected, 0);
        check("rst_count", out_count, 0);
        check("rst_cur_seq", current_seq, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        accept_word(8'hD0, 1'b0, 4'h0);
        shift_word("rst_d0", pulses);
        check("rst_d0_pulses", pulses, 9'h010);
        read_result(cnt);
        check("rst_d0_count", cnt, 1);

        // Overlap, then back-pressure while DONE
        do_reset();
        accept_word(8'b1101_1011, 1'b0, 4'h0);
        shift_word("ovl", pulses);
        check("ovl_pulses", pulses, 9'h090);
        in_valid = 1'b1;
        in_data  = 8'hD0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_count", out_count, 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_cur_seq", current_seq, 4'b1011);
            check("bp_seq_det", seq_detected, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        shift_word("bp", pulses);
        check("bp_pulses", pulses, 9'h010);
        read_result(cnt);
        check("bp_d0_count", cnt, 1);

        // Pattern spanning a word boundary
        do_reset();
        accept_word(8'b0000_0110, 1'b0, 4'h0);
        shift_word("xw1", pulses);
        check("xw1_pulses", pulses, 9'h000);
        read_result(cnt);
        check("xw1_count", cnt, 0);
        accept_word(8'b1000_0000, 1'b0, 4'h0);
        shift_word("xw2", pulses);
        check("xw2_pulses", pulses, 9'h002);
        read_result(cnt);
        check("xw2_count", cnt, 1);

        // Config ignored while busy, applied with an accept in IDLE
        do_reset();
        accept_word(8'b1101_1011, 1'b0, 4'h0);
        cfg_wr      = 1'b1;
        cfg_pattern = 4'b0000;
        shift_word("cfg_busy", pulses);
        check("cfg_busy_pulses", pulses, 9'h090);
        read_result(cnt);
        cfg_wr = 1'b0;
        check("cfg_busy_count", cnt, 2);
        accept_word(8'h00, 1'b1, 4'b0000);
        shift_word("cfg_idle", pulses);
        check("cfg_idle_pulses", pulses, 9'h1F0);
        read_result(cnt);
        check("cfg_idle_count", cnt, 5);

        // Async reset between shift edges 3 and 4
        accept_word(8'h00, 1'b0, 4'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre_seq_det", seq_detected, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_seq_det", seq_detected, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_cur_seq", current_seq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_no_result", saw_valid, 0);
        accept_word(8'hD0, 1'b0, 4'h0);
        shift_word("mid_d0", pulses);
        check("mid_d0_pulses", pulses, 9'h010);
        read_result(cnt);
        check("mid_d0_count", cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Controller that wraps a programmable bit-serial Moore pattern matcher. It accepts parallel data words over a valid/ready handshake and serialises them MSB-first into the matcher. It counts overlapping pattern matches per word and returns the count over a second valid/ready handshake. The pattern is configured at run time while the block is idle, and match history persists across consecutive words, so patterns spanning word boundaries are detected.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- DATA_W, 8, input word width in bits (≥1)
- RESET_PATTERN, 4'b1101, pattern value loaded on reset (PAT_W bits)
- CNT_W, $clog2(DATA_W+1), width of the per-word match count (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  load cfg_pattern; honoured only in IDLE
- cfg_pattern  in  PAT_W  new pattern
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word (high only in IDLE)
- in_data  in  DATA_W  input word, shifted MSB first
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_count  out  CNT_W  matches whose final bit lies in the completed word
- seq_detected  out  1  one-cycle registered pulse per match
- current_seq  out  PAT_W  history shift register, newest bit in LSB
- busy  out  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE to SHIFT on in_valid && in_ready. The edge captures in_data into the word register, clears the count and sets bit index to DATA_W-1.
- SHIFT: each edge performs the following:
  - hist <= {hist[PAT_W-2:0], word[idx]}
  - fill <= min(fill+1, PAT_W)
  - idx decrements by 1
- SHIFT to DONE on the edge that shifts idx 0.
- Match condition: next fill == PAT_W and next hist == pattern. On that edge, seq_detected <= 1 and count increments. On every other edge, seq_detected <= 0.
- Matches overlap: the history is never cleared on a match.
- DONE: out_valid = 1 and out_count = count. On out_valid && out_ready, the block moves to IDLE.
- hist and fill persist across words. Both are cleared only by reset or by an accepted cfg_wr.
- cfg_wr in IDLE sets pattern <= cfg_pattern and clears hist and fill.
- cfg_wr in SHIFT or DONE is silently ignored.
- cfg_wr and an input handshake on the same IDLE edge:
  - The config is applied first.
  - The word is accepted on that edge.
  - The word is processed with the new pattern and cleared history.
- Count cannot overflow: at most DATA_W matches per word, and CNT_W covers DATA_W.

## Timing
- Reset (async assert, any state) sets the following immediately:
  - state = IDLE
  - hist = 0, fill = 0, count = 0
  - pattern = RESET_PATTERN
  - seq_detected = 0, out_valid = 0, busy = 0, out_count = 0
  - in_ready = 1
- Reset during SHIFT or DONE discards the word in flight. No result is produced.
- Latency: with the accept on edge E0, the shifts occur on E1..E_DATA_W, and out_valid is high from E_DATA_W onward.
- Minimum word period: DATA_W+2 cycles. This covers the DONE handshake edge plus the IDLE accept edge.
- seq_detected is high during the cycle after the shift edge that completed the match. current_seq equals the pattern in that same cycle.
- While out_valid && !out_ready, the following hold stable:
  - out_count, current_seq, state
  - in_ready = 0
  - no shifts
- in_ready is a pure function of state (registered state). It has no combinational path from in_valid.
- out_valid is a pure function of state. It has no combinational path from out_ready.

## Test plan
All scenarios use PAT_W=4 and DATA_W=8.
- Reset: hold reset_n=0 for 2 cycles, then release. Required: all outputs 0, in_ready=1, and a following word 8'hD0 yields out_count=1, which proves the pattern is 1101.
- Overlap: after reset, send 8'b1101_1011. Required:
  - seq_detected pulses after shift edges 4 and 7
  - out_count=2
  - out_valid rises 8 edges after accept
- Cross-word: after reset, send 8'b0000_0110 and then 8'b1000_0000. Required: first out_count=0, second out_count=1, with the pulse after shift 1 of the second word.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1. Required: out_count stable, in_ready=0, current_seq unchanged, no seq_detected. Release out_ready, and the next word is accepted on the following IDLE edge.
- Config: while in SHIFT, drive cfg_wr with 4'b0000 and require it to be ignored (out_count=2 for 8'b1101_1011). Then, in IDLE, drive cfg_wr with 4'b0000 together with in_data=8'h00. Required: out_count=5, with no match on shifts 1-3 because fill is gated.
- Async reset mid-SHIFT: assert reset_n=0 between shift edges 3 and 4. Required:
  - busy=0 and seq_detected=0 immediately
  - no out_valid
  - pattern restored to 1101, verified by a subsequent 8'hD0 giving count 1
